// File: rtl/core_ctrl_pkg.sv
// Shared types and field positions for the two-core inter-core controller.
// Request/response bus bit positions match the cores' WB-stage encodings.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ASLEEP  = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    HALTED  = 2'd3
  } slot_state_t;

  localparam int PCO_VALID = 17;
  localparam int PCO_TGT   = 16;
  localparam int PR_VALID  = 2;
  localparam int PR_RESUME = 1;
  localparam int PR_TGT    = 0;
  localparam int PP_VALID  = 16;

endpackage

// File: rtl/core_ctrl_slot.sv
// One target core's lifecycle FSM: resolves its two incoming requests, drives pc_passed/stall_num.
// Requests sampled at edge N take effect on the registered outputs in cycle N+1; no backpressure.
module core_ctrl_slot
  import core_ctrl_pkg::*;
#(
  parameter logic [2:0] PAUSE_STALL = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_boot,
  input  logic [15:0] i_boot_pc,
  input  logic [1:0]  i_wake_vld,
  input  logic [15:0] i_wake_pc_0,
  input  logic [15:0] i_wake_pc_1,
  input  logic [1:0]  i_pr_vld,
  input  logic [1:0]  i_pr_resume,
  input  logic        i_halt,
  output slot_state_t o_state,
  output logic [16:0] o_pc_passed,
  output logic [2:0]  o_stall_num,
  output logic        o_wake_drop
);

  slot_state_t r_state;
  slot_state_t w_next;
  logic [16:0] r_pc_passed;
  logic [2:0]  r_stall_num;
  logic        w_wake_acc;
  logic        w_wake_any;
  logic        w_pr_vld;
  logic        w_pr_resume;
  logic [15:0] w_wake_pc;

  // Lower source index wins each collision; legality is judged on the winner only.
  assign w_wake_any  = |i_wake_vld;
  assign w_wake_pc   = i_wake_vld[0] ? i_wake_pc_0 : i_wake_pc_1;
  assign w_pr_vld    = |i_pr_vld;
  assign w_pr_resume = i_pr_vld[0] ? i_pr_resume[0] : i_pr_resume[1];

  always_comb begin
    w_next     = r_state;
    w_wake_acc = 1'b0;
    if (i_boot) begin
      w_next = RUNNING;
    end else begin
      case (r_state)
        ASLEEP: begin
          if (w_wake_any) begin
            w_next     = RUNNING;
            w_wake_acc = 1'b1;
          end
        end
        RUNNING: begin
          if (i_halt)                         w_next = HALTED;
          else if (w_pr_vld && !w_pr_resume) w_next = PAUSED;
        end
        PAUSED: begin
          if (i_halt)                        w_next = HALTED;
          else if (w_pr_vld && w_pr_resume) w_next = RUNNING;
        end
        default: w_next = r_state;
      endcase
    end
  end

  assign o_wake_drop = (i_wake_vld[0] && i_wake_vld[1]) || (w_wake_any && (r_state != ASLEEP));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ASLEEP;
      r_pc_passed <= '0;
      r_stall_num <= '0;
    end else begin
      r_state               <= w_next;
      r_pc_passed[PP_VALID] <= i_boot | w_wake_acc;
      if (i_boot)          r_pc_passed[15:0] <= i_boot_pc;
      else if (w_wake_acc) r_pc_passed[15:0] <= w_wake_pc;
      r_stall_num <= (w_next == PAUSED) ? PAUSE_STALL : 3'd0;
    end
  end

  assign o_state     = r_state;
  assign o_pc_passed = r_pc_passed;
  assign o_stall_num = r_stall_num;

endmodule

// File: rtl/core_ctrl.sv
// Inter-core controller: boots one core, gates request sources, routes to per-target slots, flags done/deadlock/drop.
// All outputs registered (one-cycle latency from request sampling); requests are never backpressured, only dropped.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int          BOOT_CORE   = 0,
  parameter logic [15:0] BOOT_PC     = 16'h0000,
  parameter logic [2:0]  PAUSE_STALL = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] pc_out_0,
  input  logic [17:0] pc_out_1,
  input  logic [2:0]  pr_0,
  input  logic [2:0]  pr_1,
  input  logic        halt_0,
  input  logic        halt_1,
  output logic [16:0] pc_passed_0,
  output logic [16:0] pc_passed_1,
  output logic [2:0]  stall_num_0,
  output logic [2:0]  stall_num_1,
  output logic        done,
  output logic        deadlock,
  output logic        wake_drop
);

  logic        r_booted;
  logic        r_deadlock;
  logic        r_wake_drop;
  logic        w_boot;
  logic [1:0]  w_src_run;
  logic [1:0]  w_drop;
  logic [1:0]  w_halt;
  logic        w_any_run;
  logic        w_any_paused;
  logic        w_dl_now;
  slot_state_t w_state     [2];
  logic [16:0] w_pc_passed [2];
  logic [2:0]  w_stall_num [2];

  assign w_boot = !r_booted;
  assign w_halt = {halt_1, halt_0};

  // Only a running core may issue requests; this also silences everything on the boot edge.
  assign w_src_run[0] = r_booted && (w_state[0] == RUNNING);
  assign w_src_run[1] = r_booted && (w_state[1] == RUNNING);

  for (genvar t = 0; t < 2; t++) begin : g_slot
    logic [1:0] w_wake_vld;
    logic [1:0] w_pr_vld;

    assign w_wake_vld[0] = w_src_run[0] && pc_out_0[PCO_VALID] && (pc_out_0[PCO_TGT] == 1'(t));
    assign w_wake_vld[1] = w_src_run[1] && pc_out_1[PCO_VALID] && (pc_out_1[PCO_TGT] == 1'(t));
    assign w_pr_vld[0]   = w_src_run[0] && pr_0[PR_VALID] && (pr_0[PR_TGT] == 1'(t));
    assign w_pr_vld[1]   = w_src_run[1] && pr_1[PR_VALID] && (pr_1[PR_TGT] == 1'(t));

    core_ctrl_slot #(
      .PAUSE_STALL (PAUSE_STALL)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_boot      (w_boot && (BOOT_CORE == t)),
      .i_boot_pc   (BOOT_PC),
      .i_wake_vld  (w_wake_vld),
      .i_wake_pc_0 (pc_out_0[15:0]),
      .i_wake_pc_1 (pc_out_1[15:0]),
      .i_pr_vld    (w_pr_vld),
      .i_pr_resume ({pr_1[PR_RESUME], pr_0[PR_RESUME]}),
      .i_halt      (w_halt[t]),
      .o_state     (w_state[t]),
      .o_pc_passed (w_pc_passed[t]),
      .o_stall_num (w_stall_num[t]),
      .o_wake_drop (w_drop[t])
    );
  end

  assign w_any_run    = (w_state[0] == RUNNING) || (w_state[1] == RUNNING);
  assign w_any_paused = (w_state[0] == PAUSED)  || (w_state[1] == PAUSED);
  assign w_dl_now     = r_booted && !w_any_run && w_any_paused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_booted    <= 1'b0;
      r_deadlock  <= 1'b0;
      r_wake_drop <= 1'b0;
    end else begin
      r_booted    <= 1'b1;
      r_deadlock  <= r_deadlock | w_dl_now;
      r_wake_drop <= r_wake_drop | (|w_drop);
    end
  end

  assign pc_passed_0 = w_pc_passed[0];
  assign pc_passed_1 = w_pc_passed[1];
  assign stall_num_0 = w_stall_num[0];
  assign stall_num_1 = w_stall_num[1];
  assign done        = r_booted && !w_any_run && !w_any_paused;
  assign deadlock    = r_deadlock | w_dl_now;
  assign wake_drop   = r_wake_drop;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed-vector bench for core_ctrl: boot, wake, pause/resume, collisions, deadlock, reset, halt.
module tb_core_ctrl;

  logic        clk;
  logic        rst_n;
  logic [17:0] pc_out_0, pc_out_1;
  logic [2:0]  pr_0, pr_1;
  logic        halt_0, halt_1;
  logic [16:0] pc_passed_0, pc_passed_1;
  logic [2:0]  stall_num_0, stall_num_1;
  logic        done, deadlock, wake_drop;

  int n_checks = 0;
  int n_errors = 0;

  core_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_out_0    (pc_out_0),
    .pc_out_1    (pc_out_1),
    .pr_0        (pr_0),
    .pr_1        (pr_1),
    .halt_0      (halt_0),
    .halt_1      (halt_1),
    .pc_passed_0 (pc_passed_0),
    .pc_passed_1 (pc_passed_1),
    .stall_num_0 (stall_num_0),
    .stall_num_1 (stall_num_1),
    .done        (done),
    .deadlock    (deadlock),
    .wake_drop   (wake_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; request inputs return idle afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    pc_out_0 = '0;
    pc_out_1 = '0;
    pr_0     = '0;
    pr_1     = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    pc_out_0 = '0;
    pc_out_1 = '0;
    pr_0     = '0;
    pr_1     = '0;
    halt_0   = 1'b0;
    halt_1   = 1'b0;
    tick();
    tick();
    chk("rst_pp0", 32'(pc_passed_0), 32'h0);
    chk("rst_pp1", 32'(pc_passed_1), 32'h0);
    chk("rst_st0", 32'(stall_num_0), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_dl", 32'(deadlock), 32'h0);
    chk("rst_drop", 32'(wake_drop), 32'h0);

    rst_n = 1'b1;
    tick();
    chk("boot_pp0", 32'(pc_passed_0), 32'h10000);
    chk("boot_st0", 32'(stall_num_0), 32'h0);
    chk("boot_done", 32'(done), 32'h0);
    tick();
    chk("boot_pulse_end", 32'(pc_passed_0), 32'h00000);

    pc_out_0 = 18'h3_0040;
    tick();
    chk("wake_pp1", 32'(pc_passed_1), 32'h10040);
    tick();
    chk("wake_pulse_end", 32'(pc_passed_1), 32'h00040);
    chk("wake_nodrop", 32'(wake_drop), 32'h0);
    pc_out_0 = 18'h3_0077;
    tick();
    chk("rewake_nopulse", 32'(pc_passed_1), 32'h00040);
    chk("rewake_drop", 32'(wake_drop), 32'h1);

    pr_0 = 3'b101;
    tick();
    chk("pause1", 32'(stall_num_1), 32'h6);
    pr_1 = 3'b100;
    tick();
    chk("paused_src_ignored", 32'(stall_num_0), 32'h0);
    pr_0 = 3'b111;
    tick();
    chk("resume1", 32'(stall_num_1), 32'h0);
    pr_0 = 3'b110;
    tick();
    chk("resume_running_ign", 32'(stall_num_0), 32'h0);

    pr_0 = 3'b100;
    pr_1 = 3'b100;
    tick();
    chk("coll_st0", 32'(stall_num_0), 32'h6);
    chk("coll_st1", 32'(stall_num_1), 32'h0);
    chk("coll_nodl", 32'(deadlock), 32'h0);
    pr_1 = 3'b110;
    tick();
    chk("resume0_by1", 32'(stall_num_0), 32'h0);

    pr_0 = 3'b101;
    pr_1 = 3'b100;
    tick();
    chk("mutual_st0", 32'(stall_num_0), 32'h6);
    chk("mutual_st1", 32'(stall_num_1), 32'h6);
    chk("mutual_dl", 32'(deadlock), 32'h1);
    chk("mutual_done", 32'(done), 32'h0);
    tick();
    chk("dl_sticky", 32'(deadlock), 32'h1);

    rst_n = 1'b0;
    tick();
    chk("mrst_st1", 32'(stall_num_1), 32'h0);
    chk("mrst_st0", 32'(stall_num_0), 32'h0);
    chk("mrst_pp1", 32'(pc_passed_1), 32'h0);
    chk("mrst_dl", 32'(deadlock), 32'h0);
    chk("mrst_drop", 32'(wake_drop), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("reboot_pp0", 32'(pc_passed_0), 32'h10000);

    pc_out_0 = 18'h3_1234;
    tick();
    chk("wake2_pp1", 32'(pc_passed_1), 32'h11234);
    chk("wake2_done", 32'(done), 32'h0);

    halt_0 = 1'b1;
    pr_0   = 3'b100;
    tick();
    chk("halt_st0", 32'(stall_num_0), 32'h0);
    chk("halt_done", 32'(done), 32'h0);
    pc_out_0 = 18'h3_0000;
    tick();
    chk("halted_src_nodrop", 32'(wake_drop), 32'h0);
    halt_1 = 1'b1;
    tick();
    chk("allhalt_done", 32'(done), 32'h1);
    chk("allhalt_dl", 32'(deadlock), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
